// File: rtl/dmem_arbiter_if.sv
// One requester's view of the shared data memory: request fields in, grant and read response out.
interface dmem_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 4
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory shared by CPU port A and loader port B with round-robin
// tie-breaking, one-cycle read latency and a saturating conflict counter.
//
// Response pipe states (per port):
//   state | meaning
//   IDLE  | no read data due this cycle
//   RESP  | rvalid asserted; rdata holds the word read in the previous (grant) cycle
module dmem_arbiter #(
  parameter int AW = 4,
  parameter int DW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  dmem_arbiter_if.slave a,
  dmem_arbiter_if.slave b,
  output logic [CW-1:0] conflict_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic          last_grant;
  logic          a_gnt;
  logic          b_gnt;
  logic [0:0]    a_state;
  logic [0:0]    b_state;
  logic [DW-1:0] a_rdata;
  logic [DW-1:0] b_rdata;

  // On a tie the port that did not win last time is served.
  assign a_gnt = a.req & (~b.req | (last_grant == LAST_B));
  assign b_gnt = b.req & (~a.req | (last_grant == LAST_A));

  assign a.gnt    = a_gnt;
  assign b.gnt    = b_gnt;
  assign a.rvalid = (a_state == ST_RESP);
  assign b.rvalid = (b_state == ST_RESP);
  assign a.rdata  = a_rdata;
  assign b.rdata  = b_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= LAST_B;
    end else if (a_gnt) begin
      last_grant <= LAST_A;
    end else if (b_gnt) begin
      last_grant <= LAST_B;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < (1 << AW); i++) begin
        mem[i] <= '0;
      end
    end else if (a_gnt && a.we) begin
      mem[a.addr] <= a.wdata;
    end else if (b_gnt && b.we) begin
      mem[b.addr] <= b.wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_state <= ST_IDLE;
      a_rdata <= '0;
    end else if (a_gnt && !a.we) begin
      a_state <= ST_RESP;
      a_rdata <= mem[a.addr];
    end else begin
      a_state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_state <= ST_IDLE;
      b_rdata <= '0;
    end else if (b_gnt && !b.we) begin
      b_state <= ST_RESP;
      b_rdata <= mem[b.addr];
    end else begin
      b_state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_cnt <= '0;
    end else if (a.req && b.req && (conflict_cnt != {CW{1'b1}})) begin
      conflict_cnt <= conflict_cnt + CW'(1);
    end
  end

endmodule
